// File: rtl/axi_burst_sched.sv
// Burst scheduler for a MIG AXI master: arbitrates write/read bursts one at a time
// and walks each direction's address pointer through its circular region.
module axi_burst_sched #(
  parameter int unsigned ADDR_W         = 30,
  parameter int unsigned CNT_W          = 10,
  parameter int unsigned BYTES_PER_BEAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calib_done,
  input  logic [ADDR_W-1:0] wr_beg_addr,
  input  logic [ADDR_W-1:0] wr_end_addr,
  input  logic [ADDR_W-1:0] rd_beg_addr,
  input  logic [ADDR_W-1:0] rd_end_addr,
  input  logic [7:0]        wr_burst_len,
  input  logic [7:0]        rd_burst_len,
  input  logic [CNT_W-1:0]  wr_fifo_cnt,
  input  logic [CNT_W-1:0]  rd_fifo_free,
  input  logic              rd_mem_enable,
  input  logic              wr_addr_rst,
  input  logic              rd_addr_rst,
  output logic              wr_start,
  output logic              rd_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        wr_len,
  output logic [7:0]        rd_len,
  input  logic              wr_done,
  input  logic              rd_done,
  input  logic              wr_resp_err,
  input  logic              rd_resp_err,
  output logic              busy,
  output logic              err_flag
);

  localparam int unsigned AW2 = ADDR_W + 2;
  localparam int unsigned CW  = ((CNT_W > 8) ? CNT_W : 8) + 1;

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] wr_cur, rd_cur;
  logic              last_rd;
  logic              init_pend;
  logic              wr_rst_pend, rd_rst_pend;
  logic              wr_elig, rd_elig, grant_wr, grant_rd;

  // Next burst address; wraps to beg when the following burst would cross last.
  function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] addr,
                                                input logic [ADDR_W-1:0] beg,
                                                input logic [ADDR_W-1:0] last,
                                                input logic [7:0]        len);
    logic [AW2-1:0] step;
    logic [AW2-1:0] nxt;
    step = (AW2'(len) + AW2'(1)) * AW2'(BYTES_PER_BEAT);
    nxt  = AW2'(addr) + step;
    if (nxt + step - AW2'(1) > AW2'(last))
      return beg;
    return nxt[ADDR_W-1:0];
  endfunction

  always_comb begin
    wr_elig  = calib_done && (CW'(wr_fifo_cnt) >= CW'(wr_burst_len) + CW'(1));
    rd_elig  = calib_done && rd_mem_enable &&
               (CW'(rd_fifo_free) >= CW'(rd_burst_len) + CW'(1));
    grant_wr = wr_elig && (!rd_elig || last_rd);
    grant_rd = rd_elig && !grant_wr;
    // A pointer load scheduled for this edge is honoured by a grant on the same edge.
    wr_cur   = (init_pend || wr_addr_rst) ? wr_beg_addr : wr_ptr;
    rd_cur   = (init_pend || rd_addr_rst) ? rd_beg_addr : rd_ptr;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_start    <= 1'b0;
      rd_start    <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wr_len      <= '0;
      rd_len      <= '0;
      err_flag    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_rd     <= 1'b1;
      init_pend   <= 1'b1;
      wr_rst_pend <= 1'b0;
      rd_rst_pend <= 1'b0;
    end else begin
      wr_start  <= 1'b0;
      rd_start  <= 1'b0;
      init_pend <= 1'b0;
      if (init_pend || (wr_addr_rst && state != WR_BUSY)) wr_ptr <= wr_beg_addr;
      if (init_pend || (rd_addr_rst && state != RD_BUSY)) rd_ptr <= rd_beg_addr;

      case (state)
        IDLE: begin
          if (grant_wr) begin
            state    <= WR_BUSY;
            wr_start <= 1'b1;
            wr_addr  <= wr_cur;
            wr_len   <= wr_burst_len;
            last_rd  <= 1'b0;
          end else if (grant_rd) begin
            state    <= RD_BUSY;
            rd_start <= 1'b1;
            rd_addr  <= rd_cur;
            rd_len   <= rd_burst_len;
            last_rd  <= 1'b1;
          end
        end
        WR_BUSY: begin
          if (wr_done) begin
            state       <= IDLE;
            wr_rst_pend <= 1'b0;
            if (wr_resp_err) err_flag <= 1'b1;
            if (wr_addr_rst || wr_rst_pend) wr_ptr <= wr_beg_addr;
            else wr_ptr <= advance(wr_addr, wr_beg_addr, wr_end_addr, wr_len);
          end else if (wr_addr_rst) begin
            wr_rst_pend <= 1'b1;
          end
        end
        RD_BUSY: begin
          if (rd_done) begin
            state       <= IDLE;
            rd_rst_pend <= 1'b0;
            if (rd_resp_err) err_flag <= 1'b1;
            if (rd_addr_rst || rd_rst_pend) rd_ptr <= rd_beg_addr;
            else rd_ptr <= advance(rd_addr, rd_beg_addr, rd_end_addr, rd_len);
          end else if (rd_addr_rst) begin
            rd_rst_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_burst_sched.md
AXI_BURST_SCHED -- requirements
Module: axi_burst_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_W, default 30, giving the AXI byte-address width.
REQ-002 The block SHALL have parameter CNT_W, default 10, giving the width of the FIFO occupancy and free-space counts.
REQ-003 The block SHALL have parameter BYTES_PER_BEAT, default 8, giving the bytes per data beat of the 64-bit AXI bus.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk, in, 1: MIG ui_clk; all logic is synchronous to it.
- rst_n, in, 1: asynchronous active-low reset.
- calib_done, in, 1: DDR3 initialisation complete.
- wr_beg_addr / wr_end_addr, in, ADDR_W: write region; first byte and last byte, inclusive.
- rd_beg_addr / rd_end_addr, in, ADDR_W: read region; first byte and last byte, inclusive.
- wr_burst_len / rd_burst_len, in, 8: AXI awlen/arlen encoding; beats = len+1.
- wr_fifo_cnt, in, CNT_W: 64-bit words available in the write FIFO.
- rd_fifo_free, in, CNT_W: 64-bit words of free space in the read FIFO.
- rd_mem_enable, in, 1: reads permitted.
- wr_addr_rst / rd_addr_rst, in, 1: single-cycle pointer-reset pulses, already synchronised to clk.
- wr_start / rd_start, out, 1: single-cycle burst-start pulse to the AXI master.
- wr_addr / rd_addr, out, ADDR_W: burst address.
- wr_len / rd_len, out, 8: burst length.
- wr_done / rd_done, in, 1: single-cycle pulse; the burst is finished (write: B response received; read: RLAST accepted).
- wr_resp_err / rd_resp_err, in, 1: qualified by the matching done pulse; the response was not OKAY.
- busy, out, 1: a burst is outstanding.
- err_flag, out, 1: sticky error indication.

Function
REQ-005 The block SHALL implement a state machine with states IDLE, WR_BUSY and RD_BUSY, and SHALL have at most one burst outstanding at any time.
REQ-006 Write eligibility SHALL be: calib_done=1 and wr_fifo_cnt >= wr_burst_len+1.
REQ-007 Read eligibility SHALL be: calib_done=1, rd_mem_enable=1 and rd_fifo_free >= rd_burst_len+1.
REQ-008 In IDLE, arbitration SHALL be round-robin when both directions are eligible: grant the direction not granted last; the last-grant bit resets to "read", so write wins first.
REQ-009 When only one direction is eligible, that direction SHALL be granted.
REQ-010 On a grant, the machine SHALL move to WR_BUSY or RD_BUSY on the next edge.
REQ-011 wr_start/rd_start SHALL be high for exactly the first cycle of the BUSY state, which is 1 cycle after eligibility is seen in IDLE.
REQ-012 wr_addr/wr_len (and rd_addr/rd_len) SHALL be registered at grant and held stable until the matching done pulse.
REQ-013 In WR_BUSY the block SHALL wait for wr_done and then return to IDLE on the next edge; RD_BUSY SHALL behave the same with rd_done.
- A done pulse for the non-active direction SHALL be ignored.
- wr_done and rd_start SHALL never overlap for the same state.
REQ-014 The earliest next grant SHALL occur in the IDLE cycle after return, giving a minimum start-to-start spacing of done + 2 cycles.
REQ-015 On done, the pointer SHALL advance with step = (len+1)*BYTES_PER_BEAT:
- next = addr + step;
- if next + step - 1 > end_addr, next = beg_addr.
- Arithmetic SHALL be ADDR_W+2 bits wide, with no overflow.
REQ-016 A region smaller than one burst (beg + step - 1 > end) SHALL cause every burst to issue at beg_addr.
REQ-017 A pointer-reset pulse SHALL act as follows:
- In IDLE, or not during the matching direction's BUSY, the pointer SHALL load beg_addr on the next edge.
- During the matching direction's BUSY, the request SHALL be latched and applied at done instead of the advance.
- When done and the reset pulse coincide, the reset SHALL win.
REQ-018 A pulse of calib_done=0 SHALL block new grants only and SHALL NOT abort an outstanding burst.
REQ-019 err_flag SHALL set on a done pulse with its resp_err=1 and clear only on reset.
REQ-020 busy SHALL equal (state != IDLE).
REQ-021 Eligibility SHALL be evaluated only in IDLE; FIFO count changes during BUSY SHALL have no effect.

Reset
REQ-022 Asserting rst_n=0 SHALL asynchronously force:
- state=IDLE;
- wr_start=rd_start=0, busy=0, err_flag=0;
- wr_addr=rd_addr=0, wr_len=rd_len=0;
- internal pointers loaded with 0, last-grant=read, pending pointer resets cleared.
REQ-023 Following the first edge after rst_n deassertion, the internal pointers SHALL load wr_beg_addr/rd_beg_addr.
REQ-024 Reset mid-burst SHALL abandon the burst; a done pulse arriving afterwards SHALL be ignored.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Single write: calib_done=1, beg=0x0, end=0xFFF, len=15, wr_fifo_cnt=16 -> wr_start 1 cycle later with wr_addr=0x0, wr_len=15; after wr_done, next burst at 0x80.
- Wrap: beg=0x0, end=0xFF, len=15 -> addresses 0x0, 0x80, 0x0, 0x80 across four bursts.
- Contention: both eligible continuously, len=7 -> grants W,R,W,R; read addresses 0x0, 0x40.
- Gating: rd_mem_enable=0, or rd_fifo_free=7 with rd_len=7 -> no rd_start; raising free space to 8 -> rd_start.
- Pointer reset: wr_addr_rst pulsed mid-WR_BUSY at addr 0x80 -> after done, next wr_addr=beg (0x0), not 0x100; pulse coincident with wr_done -> same result.
- Error and reset: wr_done with wr_resp_err=1 -> err_flag=1 until rst_n=0; rst_n=0 during RD_BUSY -> busy=0 immediately, and a later rd_done is ignored.
